// File: rtl/plc_lutram_pkg.sv
// plc_lutram_pkg: shared constants, FSM states and address-width helper for the LUTRAM cluster
package plc_lutram_pkg;
  localparam string WM_NORMAL = "NORMAL";
  localparam string WM_WRITETHROUGH = "WRITETHROUGH";
  localparam int BANK_AW = 4;
  localparam int BANK_WORDS = 1 << BANK_AW;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/plc_lutram_clr_seq.sv
// plc_lutram_clr_seq: clear FSM stepping a zero-write strobe through every word address
module plc_lutram_clr_seq import plc_lutram_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       LSRN,
  input  logic                       CLR,
  output logic                       BUSY,
  output logic [addr_w(DEPTH)-1:0]   clr_addr,
  output logic                       clr_we
);
  localparam int AW = addr_w(DEPTH);
  clr_state_e state, state_nxt;
  logic [AW:0] cnt, cnt_nxt, cnt_inc;
  always_ff @(posedge CLK or negedge LSRN)
    if (!LSRN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  // the last word is written when the incremented count reaches DEPTH (MSB set)
  assign cnt_inc = cnt + (AW+1)'(1);
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    state_nxt = (state == IDLE) ? (CLR ? CLEAR : IDLE) : (cnt_inc[AW] ? IDLE : CLEAR);
    cnt_nxt   = (state == IDLE) ? (CLR ? '0 : cnt) : cnt_inc;
  end
  assign BUSY     = state == CLEAR;
  assign clr_we   = state == CLEAR;
  assign clr_addr = cnt[AW-1:0];
endmodule

// File: rtl/plc_lutram_array.sv
// plc_lutram_array: banked distributed RAM with optional registered read, write-through and clear sequencer
module plc_lutram_array import plc_lutram_pkg::*; #(
  parameter int                    WIDTH      = 4,
  parameter int                    DEPTH      = 16,
  parameter int                    REG_OUT    = 0,
  parameter string                 WRITE_MODE = WM_NORMAL,
  parameter logic [WIDTH*DEPTH-1:0] INITVAL   = '0
) (
  input  logic                     CLK,
  input  logic                     LSRN,
  input  logic                     WRE,
  input  logic [addr_w(DEPTH)-1:0] WAD,
  input  logic [WIDTH-1:0]         WD,
  input  logic [addr_w(DEPTH)-1:0] RAD,
  input  logic                     RE,
  input  logic                     CLR,
  output logic [WIDTH-1:0]         RDO,
  output logic [addr_w(DEPTH)-1:0] WADO,
  output logic [WIDTH-1:0]         WDO,
  output logic                     BUSY
);
  localparam int AW = addr_w(DEPTH);
  localparam int NB = DEPTH / BANK_WORDS;
  localparam int BB = BANK_WORDS * WIDTH;
  localparam bit WT = WRITE_MODE == WM_WRITETHROUGH;
  logic busy, clr_we, mem_we, user_we;
  logic [AW-1:0] clr_addr, mem_wa;
  logic [WIDTH-1:0] mem_wd, rd_word, rd_next, rdo_q;
  logic [BB-1:0] banks [NB];
  plc_lutram_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .CLK, .LSRN, .CLR, .BUSY(busy), .clr_addr, .clr_we
  );
  assign BUSY    = busy;
  assign user_we = WRE & ~busy;
  assign mem_we  = clr_we | user_we;
  assign mem_wa  = clr_we ? clr_addr : WAD;
  assign mem_wd  = clr_we ? '0 : WD;
  // one 16-word bank per packed slice; contents survive reset
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [BB-1:0] bank_q = INITVAL[b*BB +: BB];
    always_ff @(posedge CLK)
      if (mem_we && int'(mem_wa >> BANK_AW) == b)
        bank_q[int'(mem_wa[BANK_AW-1:0])*WIDTH +: WIDTH] <= mem_wd;
    assign banks[b] = bank_q;
  end
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++)
      if (int'(RAD >> BANK_AW) == i) rd_word = banks[i][int'(RAD[BANK_AW-1:0])*WIDTH +: WIDTH];
  end
  assign rd_next = (WT && user_we && RAD == WAD) ? WD : rd_word;
  always_ff @(posedge CLK or negedge LSRN)
    if (!LSRN) rdo_q <= '0;
    else if (REG_OUT != 0 && RE) rdo_q <= rd_next;
  assign RDO = (REG_OUT != 0) ? rdo_q : rd_next;
  always_ff @(posedge CLK or negedge LSRN)
    if (!LSRN) begin
      WADO <= '0;
      WDO  <= '0;
    end else if (user_we) begin
      WADO <= WAD;
      WDO  <= WD;
    end
endmodule

// File: tb/tb_plc_lutram_array.sv
// tb_plc_lutram_array: randomized and directed checks of the LUTRAM cluster against an array model
module tb_plc_lutram_array;
  localparam logic [63:0] INIT_A = 64'h0000_0000_0000_A000;
  logic clk = 0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic lsrn_a, wre_a, re_a, clr_a;
  logic [3:0] wad_a, wd_a, rad_a;
  logic [3:0] rdo_an, rdo_rn, rdo_rw, wado_an, wado_rn, wado_rw, wdo_an, wdo_rn, wdo_rw;
  logic busy_an, busy_rn, busy_rw;
  logic lsrn_b, wre_b, re_b, clr_b, busy_b;
  logic [5:0] wad_b, rad_b, wado_b;
  logic [3:0] wd_b, rdo_b, wdo_b;
  logic [3:0] m_an [16];
  logic [3:0] m_r [16];
  logic [3:0] e_rn, e_rw, e_wado, e_wdo;

  plc_lutram_array #(.WIDTH(4), .DEPTH(16), .REG_OUT(0), .WRITE_MODE("NORMAL"), .INITVAL(INIT_A)) dut_an (
    .CLK(clk), .LSRN(lsrn_a), .WRE(wre_a), .WAD(wad_a), .WD(wd_a), .RAD(rad_a), .RE(re_a),
    .CLR(clr_a), .RDO(rdo_an), .WADO(wado_an), .WDO(wdo_an), .BUSY(busy_an));
  plc_lutram_array #(.WIDTH(4), .DEPTH(16), .REG_OUT(1), .WRITE_MODE("NORMAL")) dut_rn (
    .CLK(clk), .LSRN(lsrn_a), .WRE(wre_a), .WAD(wad_a), .WD(wd_a), .RAD(rad_a), .RE(re_a),
    .CLR(clr_a), .RDO(rdo_rn), .WADO(wado_rn), .WDO(wdo_rn), .BUSY(busy_rn));
  plc_lutram_array #(.WIDTH(4), .DEPTH(16), .REG_OUT(1), .WRITE_MODE("WRITETHROUGH")) dut_rw (
    .CLK(clk), .LSRN(lsrn_a), .WRE(wre_a), .WAD(wad_a), .WD(wd_a), .RAD(rad_a), .RE(re_a),
    .CLR(clr_a), .RDO(rdo_rw), .WADO(wado_rw), .WDO(wdo_rw), .BUSY(busy_rw));
  plc_lutram_array #(.WIDTH(4), .DEPTH(64), .REG_OUT(0), .WRITE_MODE("WRITETHROUGH")) dut_b (
    .CLK(clk), .LSRN(lsrn_b), .WRE(wre_b), .WAD(wad_b), .WD(wd_b), .RAD(rad_b), .RE(re_b),
    .CLR(clr_b), .RDO(rdo_b), .WADO(wado_b), .WDO(wdo_b), .BUSY(busy_b));

  // advance one edge of group A, updating the reference model from the current inputs
  task automatic edge_a();
    if (re_a) begin
      e_rn = m_r[rad_a];
      e_rw = (wre_a && rad_a == wad_a) ? wd_a : m_r[rad_a];
    end
    if (wre_a) begin
      m_an[wad_a] = wd_a;
      m_r[wad_a]  = wd_a;
      e_wado = wad_a;
      e_wdo  = wd_a;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    {wre_a, re_a, clr_a, wad_a, wd_a, rad_a} = '0;
    {wre_b, re_b, clr_b, wad_b, wd_b, rad_b} = '0;
    lsrn_a = 0; lsrn_b = 0;
    for (int i = 0; i < 16; i++) begin m_an[i] = INIT_A[i*4 +: 4]; m_r[i] = '0; end
    {e_rn, e_rw, e_wado, e_wdo} = '0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (busy_an !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_an); end
    n_chk++; if (wado_an !== 4'h0) begin n_fail++; $display("FAIL reset_wado got %h exp 0", wado_an); end
    n_chk++; if (wdo_an !== 4'h0) begin n_fail++; $display("FAIL reset_wdo got %h exp 0", wdo_an); end
    n_chk++; if (rdo_rn !== 4'h0 || rdo_rw !== 4'h0) begin n_fail++; $display("FAIL reset_rdo_reg got %h/%h exp 0", rdo_rn, rdo_rw); end
    n_chk++; if (busy_b !== 1'b0 || wado_b !== 6'h0) begin n_fail++; $display("FAIL reset_big got busy=%b wado=%h exp 0", busy_b, wado_b); end
    lsrn_a = 1; lsrn_b = 1; rad_a = 3;
    @(posedge clk); #1;
    n_chk++; if (rdo_an !== 4'hA) begin n_fail++; $display("FAIL initval_word3 got %h exp a", rdo_an); end
    n_chk++; if (busy_an !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b exp 0", busy_an); end
  endtask

  task automatic test_write_read();
    wre_a = 1; wad_a = 7; wd_a = 5; rad_a = 7; re_a = 0; #1;
    n_chk++; if (rdo_an !== 4'h0) begin n_fail++; $display("FAIL normal_no_bypass got %h exp 0", rdo_an); end
    edge_a();
    wre_a = 0; #1;
    n_chk++; if (rdo_an !== 4'h5) begin n_fail++; $display("FAIL async_after_write got %h exp 5", rdo_an); end
    n_chk++; if (wado_an !== 4'h7 || wdo_an !== 4'h5) begin n_fail++; $display("FAIL write_echo got %h/%h exp 7/5", wado_an, wdo_an); end
  endtask

  task automatic test_same_addr_reg();
    wre_a = 1; wad_a = 2; wd_a = 1; re_a = 0; rad_a = 0;
    edge_a();
    wd_a = 9; rad_a = 2; re_a = 1;
    edge_a();
    wre_a = 0; re_a = 0; #1;
    n_chk++; if (rdo_rn !== 4'h1) begin n_fail++; $display("FAIL rdw_normal got %h exp 1", rdo_rn); end
    n_chk++; if (rdo_rw !== 4'h9) begin n_fail++; $display("FAIL rdw_writethrough got %h exp 9", rdo_rw); end
    re_a = 1;
    edge_a();
    re_a = 0; rad_a = 5;
    edge_a();
    n_chk++; if (rdo_rn !== 4'h9 || rdo_rw !== 4'h9) begin n_fail++; $display("FAIL reg_hold got %h/%h exp 9/9", rdo_rn, rdo_rw); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      wre_a = 1'($urandom); re_a = 1'($urandom);
      wad_a = 4'($urandom); wd_a = 4'($urandom);
      rad_a = ($urandom_range(0, 3) == 0) ? wad_a : 4'($urandom);
      #1;
      n_chk++; if (rdo_an !== m_an[rad_a]) begin n_fail++; $display("FAIL rand_async k=%0d got %h exp %h", k, rdo_an, m_an[rad_a]); end
      edge_a();
      n_chk++; if (rdo_rn !== e_rn) begin n_fail++; $display("FAIL rand_reg_normal k=%0d got %h exp %h", k, rdo_rn, e_rn); end
      n_chk++; if (rdo_rw !== e_rw) begin n_fail++; $display("FAIL rand_reg_wt k=%0d got %h exp %h", k, rdo_rw, e_rw); end
      n_chk++; if (wado_an !== e_wado || wdo_an !== e_wdo) begin n_fail++; $display("FAIL rand_echo k=%0d got %h/%h exp %h/%h", k, wado_an, wdo_an, e_wado, e_wdo); end
    end
    wre_a = 0; re_a = 0;
  endtask

  task automatic test_clr_with_write();
    int n = 0;
    clr_a = 1; wre_a = 1; wad_a = 15; wd_a = 3; rad_a = 15; re_a = 0;
    edge_a();
    clr_a = 0; wre_a = 0; #1;
    n_chk++; if (busy_an !== 1'b1 || rdo_an !== 4'h3) begin n_fail++; $display("FAIL clrw_start got busy=%b rdo=%h exp 1/3", busy_an, rdo_an); end
    while (busy_an === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
    n_chk++; if (n != 16) begin n_fail++; $display("FAIL clrw_duration got %0d exp 16", n); end
    n_chk++; if (wado_an !== 4'hF || wdo_an !== 4'h3) begin n_fail++; $display("FAIL clrw_echo got %h/%h exp f/3", wado_an, wdo_an); end
    for (int a = 0; a < 16; a++) begin
      m_an[a] = '0; m_r[a] = '0; rad_a = 4'(a); #1;
      n_chk++; if (rdo_an !== 4'h0) begin n_fail++; $display("FAIL clrw_zero a=%0d got %h exp 0", a, rdo_an); end
    end
  endtask

  task automatic test_clear();
    int n = 0;
    for (int a = 0; a < 64; a++) begin
      wre_b = 1; wad_b = 6'(a); wd_b = 4'hF; rad_b = 6'(a); #1;
      n_chk++; if (rdo_b !== 4'hF) begin n_fail++; $display("FAIL wt_bypass a=%0d got %h exp f", a, rdo_b); end
      @(posedge clk); #1;
    end
    wre_b = 0; rad_b = 0; #1;
    n_chk++; if (rdo_b !== 4'hF) begin n_fail++; $display("FAIL fill_readback got %h exp f", rdo_b); end
    clr_b = 1;
    @(posedge clk); #1;
    clr_b = 0; wre_b = 1; wd_b = 4'h5;
    while (busy_b === 1'b1 && n < 200) begin
      n++; clr_b = (n == 30); wad_b = 6'($urandom);
      @(posedge clk); #1;
    end
    clr_b = 0; wre_b = 0;
    n_chk++; if (n != 64) begin n_fail++; $display("FAIL clear_duration got %0d exp 64", n); end
    n_chk++; if (wado_b !== 6'd63 || wdo_b !== 4'hF) begin n_fail++; $display("FAIL busy_write_dropped got %h/%h exp 3f/f", wado_b, wdo_b); end
    for (int a = 0; a < 64; a++) begin
      rad_b = 6'(a); #1;
      n_chk++; if (rdo_b !== 4'h0) begin n_fail++; $display("FAIL clear_zero a=%0d got %h exp 0", a, rdo_b); end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < 64; a++) begin
      wre_b = 1; wad_b = 6'(a); wd_b = 4'hF;
      @(posedge clk); #1;
    end
    wre_b = 0; clr_b = 1;
    @(posedge clk); #1;
    clr_b = 0;
    repeat (10) @(posedge clk);
    #1 lsrn_b = 0; #1;
    n_chk++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy_b); end
    n_chk++; if (wado_b !== 6'h0 || wdo_b !== 4'h0) begin n_fail++; $display("FAIL abort_echo got %h/%h exp 0/0", wado_b, wdo_b); end
    #2 lsrn_b = 1;
    @(posedge clk); #1;
    n_chk++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle got %b exp 0", busy_b); end
    for (int a = 0; a < 64; a++) begin
      rad_b = 6'(a); #1;
      n_chk++; if (rdo_b !== (a < 10 ? 4'h0 : 4'hF)) begin n_fail++; $display("FAIL abort_contents a=%0d got %h exp %h", a, rdo_b, (a < 10 ? 4'h0 : 4'hF)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_addr_reg();
    test_random();
    test_clr_with_write();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
